xor_reduce_unit: RTL and testbench

Parametrised sequential successor to the team's 2-input XOR gate. It accepts a packet of WIDTH-bit words over a valid/ready stream and reduces them bitwise with a selectable operator: XOR, XNOR, AND or OR. It then presents the reduced word, its parity and the beat count on an output valid/ready port. It sits between operand sources and checksum/compare logic in the COA lab datapath.

---
 rtl/xor_reduce_unit.sv | 166 ++++++++++++++++
 tb/tb_xor_reduce_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xor_reduce_unit.sv
// xor_reduce_unit: reduces a packet of WIDTH-bit words, received over a
// valid/ready stream, with a selectable bitwise operator (XOR/XNOR/AND/OR).
// The result, its parity, the beat count and an overflow flag are presented
// on a registered valid/ready output port. Between packets there is one
// bubble cycle, spent in DONE while the result is handed over.
module xor_reduce_unit #(
  parameter  int WIDTH     = 8,
  parameter  int MAX_WORDS = 16,
  localparam int CW        = $clog2(MAX_WORDS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_parity,
  output logic [CW-1:0]    out_count,
  output logic             out_overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [CW-1:0] LP_MAX_WORDS = CW'(MAX_WORDS);

  // Bitwise combine of the running value with a new word.
  function automatic logic [WIDTH-1:0] f_op(input logic [1:0]       op_sel,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] res;
    case (op_sel)
      2'b00:   res = a ^ b;
      2'b01:   res = ~(a ^ b);
      2'b10:   res = a & b;
      2'b11:   res = a | b;
      default: res = a ^ b;
    endcase
    return res;
  endfunction

  // Even/odd parity of a word: 1 when the number of ones is odd.
  function automatic logic f_parity(input logic [WIDTH-1:0] d);
    return ^d;
  endfunction

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_count_nxt;
  logic [CW-1:0]    w_count_inc;
  logic [1:0]       r_mode;
  logic [1:0]       w_mode_nxt;
  logic             w_accept;
  logic             w_enter_done;
  logic             w_ovf_nxt;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_parity;
  logic [CW-1:0]    r_out_count;
  logic             r_out_overflow;

  // Ready is a pure function of state so it rises right after reset.
  assign in_ready    = (r_state != ST_DONE);
  assign w_accept    = in_valid & in_ready;
  assign w_count_inc = r_count + CW'(1);

  // Next-state and next-accumulator logic; defaults hold every register.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_count_nxt  = r_count;
    w_mode_nxt   = r_mode;
    w_enter_done = 1'b0;
    w_ovf_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          // First beat is loaded raw; the operator only applies from beat 2.
          w_acc_nxt   = in_data;
          w_count_nxt = CW'(1);
          w_mode_nxt  = mode;
          if (in_last || (MAX_WORDS == 1)) begin
            w_state_nxt  = ST_DONE;
            w_enter_done = 1'b1;
            w_ovf_nxt    = (MAX_WORDS == 1) && !in_last;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt   = f_op(r_mode, r_acc, in_data);
          w_count_nxt = w_count_inc;
          if (in_last || (w_count_inc == LP_MAX_WORDS)) begin
            w_state_nxt  = ST_DONE;
            w_enter_done = 1'b1;
            w_ovf_nxt    = (w_count_inc == LP_MAX_WORDS) && !in_last;
          end else begin
            w_state_nxt = ST_ACCUM;
          end
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, accumulator and captured-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_acc          <= '0;
      r_count        <= '0;
      r_mode         <= 2'b00;
      r_out_valid    <= 1'b0;
      r_out_data     <= '0;
      r_out_parity   <= 1'b0;
      r_out_count    <= '0;
      r_out_overflow <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_count     <= w_count_nxt;
      r_mode      <= w_mode_nxt;
      r_out_valid <= (w_state_nxt == ST_DONE);
      // Result fields are frozen for the whole DONE residency.
      if (w_enter_done) begin
        r_out_data     <= w_acc_nxt;
        r_out_parity   <= f_parity(w_acc_nxt);
        r_out_count    <= w_count_nxt;
        r_out_overflow <= w_ovf_nxt;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_parity   = r_out_parity;
  assign out_count    = r_out_count;
  assign out_overflow = r_out_overflow;

endmodule

// File: tb/tb_xor_reduce_unit.sv
// Self-checking bench for xor_reduce_unit: directed test-plan packets with
// literal expectations, then randomized traffic checked against a packet-level
// reference model (queue of words folded at packet end).
module tb_xor_reduce_unit;

  localparam int W  = 8;
  localparam int MW = 16;
  localparam int CW = $clog2(MW + 1);

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic [1:0]    mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_parity;
  logic [CW-1:0] out_count;
  logic          out_overflow;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [W-1:0] m_words[$];
  logic [1:0]   m_mode;
  bit           m_done;
  bit           model_on;
  logic [W-1:0] e_data;
  logic         e_par;
  int           e_cnt;
  logic         e_ovf;

  xor_reduce_unit #(.WIDTH(W), .MAX_WORDS(MW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .mode(mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_parity(out_parity), .out_count(out_count), .out_overflow(out_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Fold the packet's words with the packet's operator.
  function automatic logic [W-1:0] ref_reduce();
    logic [W-1:0] r;
    r = m_words[0];
    for (int i = 1; i < m_words.size(); i++) begin
      case (m_mode)
        2'd0:    r = r ^ m_words[i];
        2'd1:    r = ~(r ^ m_words[i]);
        2'd2:    r = r & m_words[i];
        default: r = r | m_words[i];
      endcase
    end
    return r;
  endfunction

  task automatic model_clear();
    m_words.delete();
    m_done = 1'b0;
    m_mode = 2'd0;
    e_data = '0; e_par = 1'b0; e_cnt = 0; e_ovf = 1'b0;
  endtask

  // Advance the model by one clock edge using the inputs seen at that edge.
  task automatic model_step();
    if (m_done) begin
      if (out_ready) m_done = 1'b0;
    end else if (in_valid) begin
      if (m_words.size() == 0) m_mode = mode;
      m_words.push_back(in_data);
      if (in_last || m_words.size() == MW) begin
        e_data = ref_reduce();
        e_par  = ($countones(e_data) % 2) == 1;
        e_cnt  = m_words.size();
        e_ovf  = !in_last;
        m_done = 1'b1;
        m_words.delete();
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (model_on && !rst) begin
      chk("in_ready", 32'(in_ready), 32'(!m_done));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done) begin
        chk("out_data", 32'(out_data), 32'(e_data));
        chk("out_parity", 32'(out_parity), 32'(e_par));
        chk("out_count", 32'(out_count), 32'(e_cnt));
        chk("out_overflow", 32'(out_overflow), 32'(e_ovf));
      end
    end
  end

  // Present one beat and hold it until the DUT takes it (bounded).
  task automatic beat(input logic [W-1:0] d, input logic l, input logic [1:0] md);
    bit took;
    int guard;
    in_valid = 1'b1; in_data = d; in_last = l; mode = md;
    took = 1'b0; guard = 0;
    while (!took && guard < 100) begin
      took = in_ready;
      tick();
      guard++;
    end
    if (!took) chk("beat_timeout", 32'd0, 32'd1);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic chk_result(input string nm, input logic [W-1:0] d, input logic p,
                            input int c, input logic o);
    chk({nm, "_valid"}, 32'(out_valid), 32'd1);
    chk({nm, "_data"}, 32'(out_data), 32'(d));
    chk({nm, "_parity"}, 32'(out_parity), 32'(p));
    chk({nm, "_count"}, 32'(out_count), 32'(c));
    chk({nm, "_ovf"}, 32'(out_overflow), 32'(o));
    chk({nm, "_model"}, 32'(e_data), 32'(d));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({nm, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({nm, "_out_data"}, 32'(out_data), 32'd0);
    chk({nm, "_out_parity"}, 32'(out_parity), 32'd0);
    chk({nm, "_out_count"}, 32'(out_count), 32'd0);
    chk({nm, "_out_ovf"}, 32'(out_overflow), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; mode = 2'd0;
    out_ready = 1'b1; model_on = 1'b0;
    model_clear();
    #12;
    chk_zero("reset");
    rst = 1'b0;
    model_on = 1'b1;
    tick();

    // XOR 0x0F ^ 0xF0 ^ 0xAA = 0x55
    beat(8'h0F, 1'b0, 2'd0);
    beat(8'hF0, 1'b0, 2'd0);
    beat(8'hAA, 1'b1, 2'd0);
    chk_result("xor", 8'h55, 1'b0, 3, 1'b0);
    tick();
    chk("xor_valid_1cyc", 32'(out_valid), 32'd0);

    // XNOR single beat passes raw, then ~(0^0) = 0xFF
    beat(8'h81, 1'b1, 2'd1);
    chk_result("xnor1", 8'h81, 1'b0, 1, 1'b0);
    tick();
    beat(8'h00, 1'b0, 2'd1);
    beat(8'h00, 1'b1, 2'd1);
    chk_result("xnor2", 8'hFF, 1'b0, 2, 1'b0);
    tick();

    // AND retained although mode switches to OR on beat 2
    beat(8'hF0, 1'b0, 2'd2);
    beat(8'h3C, 1'b1, 2'd3);
    chk_result("and", 8'h30, 1'b0, 2, 1'b0);
    tick();
    beat(8'h01, 1'b0, 2'd3);
    beat(8'h02, 1'b0, 2'd3);
    beat(8'h04, 1'b1, 2'd3);
    chk_result("or", 8'h07, 1'b1, 3, 1'b0);
    tick();

    // Backpressure: result held, further beats refused
    out_ready = 1'b0;
    beat(8'h12, 1'b1, 2'd0);
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_result("bp", 8'h12, 1'b0, 1, 1'b0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    chk("bp_release_valid", 32'(out_valid), 32'd0);

    // Overflow at MAX_WORDS, then in_last exactly on the limit
    for (int i = 0; i < MW; i++) beat(8'h01, 1'b0, 2'd0);
    chk_result("ovf", 8'h00, 1'b0, MW, 1'b1);
    tick();
    for (int i = 0; i < MW; i++) beat(8'h01, (i == MW - 1), 2'd0);
    chk_result("ovf_last", 8'h00, 1'b0, MW, 1'b0);
    tick();

    // Async reset mid-packet
    beat(8'hAA, 1'b1, 2'd0);
    tick();
    beat(8'hAA, 1'b0, 2'd0);
    beat(8'h55, 1'b0, 2'd0);
    #1 rst = 1'b1;
    #1 chk_zero("midrst");
    model_clear();
    #1 rst = 1'b0;
    beat(8'h3C, 1'b1, 2'd0);
    chk_result("post_rst", 8'h3C, 1'b0, 1, 1'b0);
    tick();

    // Randomized traffic, checked every cycle by the compare process
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom);
      in_last   = ($urandom_range(0, 5) == 0);
      mode      = 2'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
